// File: rtl/numbotron_core_if.sv
// numbotron_core_if
//   Host-side access bus for numbotron_core: program-memory write port,
//   counter write port and counter read port.
//
//   prog_we / prog_addr / prog_data : write one program word (any state)
//   reg_we / reg_sel / reg_wdata    : write one counter (honoured only when idle/halted)
//   rd_sel / rd_data                : combinational counter read-back
//
//   master : host side (drives writes and read select)
//   slave  : core side (returns rd_data)
interface numbotron_core_if #(
  parameter int NREGS = 8,
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int IW = 3 * NREGS;

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          reg_we;
  logic [SW-1:0] reg_sel;
  logic [WIDTH-1:0] reg_wdata;
  logic [SW-1:0] rd_sel;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output prog_we, prog_addr, prog_data,
    output reg_we, reg_sel, reg_wdata,
    output rd_sel,
    input  rd_data
  );

  modport slave (
    input  prog_we, prog_addr, prog_data,
    input  reg_we, reg_sel, reg_wdata,
    input  rd_sel,
    output rd_data
  );
endinterface

// File: rtl/numbotron_core.sv
// numbotron_core
//   Counter-machine sequencer. A bank of NREGS saturating counters is driven
//   by a program of DEPTH words, each word {inc_mask, dec_mask, zero_mask}.
//   An instruction loops "dec/inc the masked counters" until any counter in
//   zero_mask reads zero, then moves to the next word. A word whose zero_mask
//   is empty halts the machine.
//
// Ports
//   clk       : clock, all state changes on its rising edge
//   rstb      : synchronous active-high reset
//   slowclk   : tick enable for the sequencer
//   step      : single-step request (rising edge is latched)
//   run_mode  : 1 = free run, 0 = single step
//   start     : leaves IDLE/HALT and begins at ip = 0
//   bus       : program / counter access (numbotron_core_if.slave)
//   zflags    : per-counter zero flags (combinational)
//   inc_regs  : inc mask of the instruction in EXEC, else 0
//   dec_regs  : dec mask of the instruction in EXEC, else 0
//   dostep    : high in each cycle an inc/dec is applied
//   ip        : instruction pointer
//   running   : state is FETCH or EXEC
//   halted    : state is HALT
//   ovf       : sticky saturation flag
module numbotron_core #(
  parameter int NREGS = 8,
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int IW = 3 * NREGS
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             slowclk,
  input  logic             step,
  input  logic             run_mode,
  input  logic             start,
  numbotron_core_if.slave  bus,
  output logic [NREGS-1:0] zflags,
  output logic [NREGS-1:0] inc_regs,
  output logic [NREGS-1:0] dec_regs,
  output logic             dostep,
  output logic [AW-1:0]    ip,
  output logic             running,
  output logic             halted,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ip_q, ip_d;
  logic             step_pending_q, step_pending_d;
  logic             step_prev_q;
  logic [NREGS-1:0] zmask_q, zmask_d;
  logic [NREGS-1:0] inc_q, inc_d;
  logic [NREGS-1:0] dec_q, dec_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             ovf_q, ovf_d;
  logic [IW-1:0]    mem_q [DEPTH];

  logic [IW-1:0]    fetch_word_s;
  logic [NREGS-1:0] f_zero_s, f_dec_s, f_inc_s;
  logic [NREGS-1:0] zflags_s;
  logic             adv_s;
  logic             step_rise_s;
  logic             ip_last_s;
  logic             pend_clr_s;
  logic             exec_apply_s;
  logic             ovf_set_s;
  logic             host_we_s;
  logic             running_s;
  logic [WIDTH-1:0] rd_data_s;

  assign fetch_word_s = mem_q[ip_q];
  assign f_zero_s     = fetch_word_s[NREGS-1:0];
  assign f_dec_s      = fetch_word_s[2*NREGS-1:NREGS];
  assign f_inc_s      = fetch_word_s[3*NREGS-1:2*NREGS];

  assign running_s   = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign adv_s       = slowclk & (run_mode | step_pending_q);
  assign step_rise_s = step & ~step_prev_q;
  assign ip_last_s   = (ip_q == AW'(DEPTH - 1));
  // Counter writes from the host would race the sequencer, so only idle/halted.
  assign host_we_s   = bus.reg_we & ~running_s;

  // Per-counter zero flags.
  always_comb begin
    zflags_s = '0;
    for (int i = 0; i < NREGS; i++) begin
      zflags_s[i] = (regs_q[i] == '0);
    end
  end

  // Counter read-back mux.
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.rd_sel == SW'(i)) begin
        rd_data_s = regs_q[i];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  // Sequencer next-state: fetch/skip/halt decisions and EXEC loop control.
  always_comb begin
    state_d      = state_q;
    ip_d         = ip_q;
    zmask_d      = zmask_q;
    inc_d        = inc_q;
    dec_d        = dec_q;
    pend_clr_s   = 1'b0;
    exec_apply_s = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d    = S_FETCH;
          ip_d       = '0;
          pend_clr_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      S_FETCH: begin
        if (adv_s) begin
          if (f_zero_s == '0) begin
            // Empty test mask marks the end of the program.
            state_d    = S_HALT;
            pend_clr_s = 1'b1;
          end else if ((f_zero_s & zflags_s) != '0) begin
            // Test already satisfied: the instruction is skipped outright.
            pend_clr_s = 1'b1;
            if (ip_last_s) begin
              state_d = S_HALT;
            end else begin
              ip_d    = ip_q + AW'(1);
              state_d = S_FETCH;
            end
          end else begin
            // The word is latched so later program writes cannot disturb it.
            state_d = S_EXEC;
            zmask_d = f_zero_s;
            inc_d   = f_inc_s;
            dec_d   = f_dec_s;
          end
        end else begin
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        if (slowclk) begin
          if ((zmask_q & zflags_s) != '0) begin
            // Loop finished; a pending step is consumed by the whole instruction.
            pend_clr_s = 1'b1;
            zmask_d    = '0;
            inc_d      = '0;
            dec_d      = '0;
            if (ip_last_s) begin
              state_d = S_HALT;
            end else begin
              ip_d    = ip_q + AW'(1);
              state_d = S_FETCH;
            end
          end else begin
            exec_apply_s = 1'b1;
          end
        end else begin
          state_d = S_EXEC;
        end
      end

      default: begin
        state_d = S_IDLE;
        ip_d    = '0;
        zmask_d = '0;
        inc_d   = '0;
        dec_d   = '0;
      end
    endcase

    // A new edge in the same cycle as a clear is kept for the next instruction.
    step_pending_d = (step_pending_q & ~pend_clr_s) | step_rise_s;
  end

  // Counter next-state: saturating inc/dec and host writes.
  always_comb begin
    ovf_set_s = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (exec_apply_s && inc_q[i] && !dec_q[i]) begin
        if (regs_q[i] == {WIDTH{1'b1}}) begin
          ovf_set_s = 1'b1;
        end else begin
          regs_d[i] = regs_q[i] + WIDTH'(1);
        end
      end else if (exec_apply_s && dec_q[i] && !inc_q[i]) begin
        if (regs_q[i] == '0) begin
          ovf_set_s = 1'b1;
        end else begin
          regs_d[i] = regs_q[i] - WIDTH'(1);
        end
      end else begin
        // Counter in both masks, or no tick: holds.
        regs_d[i] = regs_q[i];
      end

      if (host_we_s && (bus.reg_sel == SW'(i))) begin
        regs_d[i] = bus.reg_wdata;
      end else begin
        regs_d[i] = regs_d[i];
      end
    end
    ovf_d = ovf_q | ovf_set_s;
  end

  // Sequencer and counter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q        <= S_IDLE;
      ip_q           <= '0;
      step_pending_q <= 1'b0;
      step_prev_q    <= 1'b0;
      zmask_q        <= '0;
      inc_q          <= '0;
      dec_q          <= '0;
      ovf_q          <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      ip_q           <= ip_d;
      step_pending_q <= step_pending_d;
      step_prev_q    <= step;
      zmask_q        <= zmask_d;
      inc_q          <= inc_d;
      dec_q          <= dec_d;
      ovf_q          <= ovf_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign bus.rd_data = rd_data_s;
  assign zflags      = zflags_s;
  assign inc_regs    = inc_q;
  assign dec_regs    = dec_q;
  // Reset aborts an EXEC tick in the same cycle, so the pulse is suppressed too.
  assign dostep      = exec_apply_s & ~rstb;
  assign ip          = ip_q;
  assign running     = running_s;
  assign halted      = (state_q == S_HALT);
  assign ovf         = ovf_q;

endmodule

// File: doc/numbotron_core.md
NUMBOTRON_CORE -- requirements
Module: numbotron_core

Parameters
REQ-001 NREGS, 8, number of counter registers; instruction is 3*NREGS bits {inc_mask, dec_mask, zero_mask}, zero_mask in LSBs.
REQ-002 WIDTH, 8, bits per counter register.
REQ-003 DEPTH, 32, program words; AW = clog2(DEPTH) address bits.

Interface
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rstb  in  1  reset; synchronous, active-high.
REQ-006 slowclk  in  1  tick enable; the sequencer advances only in cycles where slowclk=1.
REQ-007 step  in  1  single-step request; rising edge latched as step_pending.
REQ-008 run_mode  in  1  1=free run, 0=single step.
REQ-009 start  in  1  one-cycle pulse; leaves IDLE or HALT and begins at ip=0.
REQ-010 prog_we / prog_addr / prog_data  in  1 / AW / 3*NREGS  program write port.
REQ-011 reg_we / reg_sel / reg_wdata  in  1 / clog2(NREGS) / WIDTH  counter write port.
REQ-012 rd_sel  in  clog2(NREGS)  counter read select; rd_data  out  WIDTH  combinational read.
REQ-013 zflags  out  NREGS  bit i = (reg[i]==0), combinational.
REQ-014 inc_regs / dec_regs  out  NREGS  masks of the instruction currently in EXEC, else 0.
REQ-015 dostep  out  1  one-cycle pulse in each cycle an inc/dec is applied.
REQ-016 ip  out  AW  instruction pointer; running  out  1  state is FETCH or EXEC; halted  out  1  state is HALT.
REQ-017 ovf  out  1  sticky saturation flag.

Function
REQ-018 States: IDLE, FETCH, EXEC, HALT; IDLE->FETCH and HALT->FETCH on start, ip<=0, step_pending<=0.
REQ-019 Advance condition adv = slowclk & (run_mode | step_pending); FETCH acts only when adv=1, EXEC acts only when slowclk=1.
REQ-020 FETCH with adv: instr=mem[ip]; zero_mask==0 -> HALT, ip unchanged.
REQ-021 FETCH with adv, zero_mask & zflags != 0 -> ip<=ip+1, stay FETCH, clear step_pending.
REQ-022 FETCH with adv, otherwise -> latch instr, EXEC.
REQ-023 EXEC tick: zero_mask & zflags != 0 -> ip<=ip+1, FETCH, clear step_pending, inc_regs/dec_regs<=0.
REQ-024 EXEC tick otherwise: each reg in dec_mask -1, each in inc_mask +1, dostep=1 same cycle; reg in both masks unchanged.
REQ-025 Increment of all-ones saturates at 2^WIDTH-1 and sets ovf; decrement of 0 stays 0 and sets ovf.
REQ-026 ip==DEPTH-1 and an increment of ip is due -> HALT instead (no wrap).
REQ-027 One step press executes exactly one whole instruction (skip or loop to completion).
REQ-028 prog_we writes in any state; write to the latched EXEC instruction has no effect until refetch.
REQ-029 reg_we ignored while running=1; honoured in IDLE/HALT.
REQ-030 start while running is ignored.
REQ-031 Run-mode switch takes effect at the next FETCH.

Reset
REQ-032 rstb=1: state IDLE, ip=0, all counters 0, inc_regs=dec_regs=0, dostep=0, ovf=0, step_pending=0; program memory not cleared.
REQ-033 Reset mid-EXEC aborts the instruction at once; no partial update in the reset cycle.

Verification
REQ-034 Copy loop: program {000008h? no: zero=01,dec=01,inc=02}, reg0=5, reg1=0, slowclk=1, run, start -> 5 dostep pulses, reg0=0, reg1=5, ip=1, then HALT on word of zeros.
REQ-035 Skip: instr zero_mask=04 with reg2=0 -> no dostep, ip+1 on next tick, counters unchanged.
REQ-036 Step mode: 3-word program, run_mode=0, three step edges -> ip goes 0->1->2->3, no progress without an edge.
REQ-037 Saturation: WIDTH=8, reg1=FFh, loop inc reg1 with test reg0=2 -> reg1=FFh, ovf=1, reg0=0.
REQ-038 End of memory: DEPTH=4, all words zero_mask=01 with reg0=0 -> ip reaches 3, halted=1, ip stays 3.
REQ-039 Reset in EXEC with reg0=3 -> next cycle IDLE, counters 0, dostep=0; start with reg write then reruns correctly.
